pulse_generator: RTL
====================

// Module: pulse_generator
//
// PURPOSE
// - Outbound counterpart of the asynchronous pulse capture path. It turns single-cycle trigger
//   requests from the clk domain into glitch-free output pulses for an external pin or a slower domain.
// - Pulse high-width and minimum low-gap are programmable, so the far-end detector always sees the edge.
// - Requests arriving while a pulse or gap is in progress are queued in a saturating counter.
//   Queue overflow is flagged with a sticky bit.
//
// PARAMETERS
// - WIDTH_W  8  bit width of width_cfg; maximum pulse high time is 2^WIDTH_W-1 cycles
// - GAP_W    8  bit width of gap_cfg; maximum enforced low time is 2^GAP_W-1 cycles
// - PEND_W   4  bit width of the pending-request counter; saturates at 2^PEND_W-1
//
// PORTS
// - clk          in   1        single clock; all logic is on posedge clk
// - async_rst_n  in   1        asynchronous assert, active-low reset
// - trig_in      in   1        request one pulse; sampled every cycle; a level held N cycles = N requests
// - width_cfg    in   WIDTH_W  pulse high time in cycles; 0 is treated as 1
// - gap_cfg      in   GAP_W    minimum low time after each pulse in cycles; 0 = no enforced gap
// - ovf_clr      in   1        clears the overflow flag
// - pulse_out    out  1        generated pulse; driven directly from a flop (no combinational path)
// - busy         out  1        1 when state != IDLE or pending != 0
// - pending      out  PEND_W   number of queued requests not yet started
// - overflow     out  1        sticky; a request was dropped because pending was saturated
//
// BEHAVIOUR
// - Reset (async):
//   - pulse_out, busy and overflow go to 0; pending goes to 0; state goes to IDLE.
//   - A pulse in flight is truncated immediately.
// - States:
//   - IDLE: pulse_out=0; waiting for a request.
//   - HIGH: pulse_out=1; a down-counter runs for the high time.
//   - GAP:  pulse_out=0; the down-counter enforces the low time.
// - IDLE -> HIGH:
//   - Taken when trig_in=1 or pending!=0.
//   - pulse_out rises on the first edge after trig_in is sampled (latency 1 cycle).
// - Pulse start:
//   - width_cfg and gap_cfg are latched when a pulse starts.
//   - Config changes mid-pulse have no effect on the current pulse or its gap.
// - HIGH exit:
//   - pulse_out stays 1 for exactly max(width_cfg,1) cycles.
//   - If the latched gap != 0: go to GAP.
//   - Else if pending!=0 or trig_in=1: start the next pulse.
//   - Else: go to IDLE.
// - GAP: pulse_out stays 0 for exactly the latched gap cycles.
//   - Then start the next pulse if pending!=0 or trig_in=1; else go to IDLE.
// - Back-to-back pulses with gap=0:
//   - pulse_out stays 1 continuously (merged).
//   - This configuration is legal only for edge-insensitive consumers.
// - Queueing:
//   - trig_in=1 while a pulse cannot start this cycle increments pending.
//   - Starting a pulse from the queue decrements pending.
//   - trig_in=1 on the same cycle a pulse starts consumes the trigger directly if pending==0.
//     Otherwise pending is unchanged (net +1-1).
// - Saturation:
//   - When pending==2^PEND_W-1, a trig_in that would increment pending is dropped and overflow is set.
//   - pending never wraps.
// - overflow:
//   - Cleared by ovf_clr.
//   - If a set event and ovf_clr occur in the same cycle, set wins.
// - busy updates in the same cycle as the state and pending registers (registered view).
//
// STRUCTURE
// - Package pulse_generator_pkg holds:
//   - typedef enum logic [1:0] {PG_IDLE, PG_HIGH, PG_GAP} pg_state_e
// - Single module; no sub-module.
//   - One shared down-counter, sized max(WIDTH_W,GAP_W), serves both HIGH and GAP.
//
// TESTING
// - Single pulse: width=3, gap=2, one trig_in cycle
//   -> pulse_out=1 for exactly 3 cycles starting 1 cycle after trig;
//   -> then busy=1 for 2 more cycles, then busy=0.
// - Burst: trig_in held 3 cycles, width=3, gap=2
//   -> 3 pulses, each 3 high / 2 low; pending peaks at 2; busy=0 after 15 cycles.
// - Overflow: PEND_W=2, width=10, 5 triggers during the first pulse
//   -> pending=3, overflow=1, only 4 pulses total.
//   - Then ovf_clr with trig_in=1 while pending=3 -> overflow stays 1.
// - Degenerate config: width=0 and gap=0, two triggers 1 cycle apart
//   -> each pulse is 1 cycle wide and they merge into 2 consecutive high cycles.
//   - width_cfg changed mid-pulse -> current pulse length unchanged.
// - Reset mid-operation: assert async_rst_n=0 during HIGH with pending=2
//   -> pulse_out=0 with no clock edge; pending=0, overflow=0.
//   - After release, no further pulses occur.

Source files
------------

// File: rtl/pulse_generator_pkg.sv
// Shared types and helpers for the outbound pulse generator.
package pulse_generator_pkg;

    typedef enum logic [1:0] {PG_IDLE, PG_HIGH, PG_GAP} pg_state_e;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_generator.sv
// Turns single-cycle trigger requests into glitch-free pulses with programmable high width
// and minimum low gap; overlapping requests queue in a saturating counter.
module pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int unsigned WIDTH_W = 8,
    parameter int unsigned GAP_W   = 8,
    parameter int unsigned PEND_W  = 4
) (
    input  logic               clk,
    input  logic               async_rst_n,
    input  logic               trig_in,
    input  logic [WIDTH_W-1:0] width_cfg,
    input  logic [GAP_W-1:0]   gap_cfg,
    input  logic               ovf_clr,
    output logic               pulse_out,
    output logic               busy,
    output logic [PEND_W-1:0]  pending,
    output logic               overflow
);

    localparam int unsigned CNT_W = max_w(WIDTH_W, GAP_W);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    pg_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic               pulse_q, busy_q;
    logic               want, can_start, start, ovf_set;

    always_comb begin
        want      = trig_in || (pending_q != '0);
        can_start = 1'b0;
        unique case (state_q)
            PG_IDLE: can_start = 1'b1;
            PG_HIGH: can_start = (cnt_q == '0) && (gap_q == '0);
            PG_GAP:  can_start = (cnt_q == '0);
            default: can_start = 1'b0;
        endcase
        start = can_start && want;

        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            PG_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (gap_q != '0) begin
                    state_d = PG_GAP;
                    cnt_d   = CNT_W'(gap_q) - CNT_W'(1);
                end else begin
                    state_d = PG_IDLE;
                end
            end
            PG_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = PG_IDLE;
                end
            end
            default: ;
        endcase

        // Width 0 behaves as 1: the counter holds the remaining high cycles minus one.
        if (start) begin
            state_d = PG_HIGH;
            gap_d   = gap_cfg;
            cnt_d   = (width_cfg == '0) ? '0 : CNT_W'(width_cfg) - CNT_W'(1);
        end

        pending_d = pending_q;
        ovf_set   = 1'b0;
        if (start) begin
            if ((pending_q != '0) && !trig_in) begin
                pending_d = pending_q - PEND_W'(1);
            end
        end else if (trig_in) begin
            if (pending_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= PG_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pulse_q    <= (state_d == PG_HIGH);
            busy_q     <= (state_d != PG_IDLE) || (pending_d != '0);
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
